// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply, restoring divide.
// Latency: 33 cycles from start to done; divide-by-zero and signed overflow take 1 cycle.
// No backpressure: start is sampled only while idle; flush aborts at any time.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        flush,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] opb_q;   // multiplicand (multiply) or divisor magnitude (divide)
    logic [63:0] acc_q;   // {hi/remainder, multiplier/quotient}
    logic        neg_q;   // final result must be negated

    // Operand decode at the accepting edge
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_start;
    logic        div_zero;
    logic        div_ovf;
    logic        fast;
    logic [31:0] fast_res;

    // One iteration of the datapath
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;

    // Final result shaping
    logic [63:0] prod_fin;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;
    logic [31:0] fin_res;
    logic        last_iter;

    assign last_iter = (cnt == 5'd31);

    // Sign handling and special-case detection for the incoming request
    always_comb begin
        a_sgn     = a[31] && ((op == OP_MULH) || (op == OP_MULHSU) ||
                              (op == OP_DIV)  || (op == OP_REM));
        b_sgn     = b[31] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        a_mag     = a_sgn ? (~a + 32'd1) : a;
        b_mag     = b_sgn ? (~b + 32'd1) : b;
        // Remainder takes the dividend's sign; everything else the product of signs
        neg_start = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero  = op[2] && (b == 32'd0);
        div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        fast      = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = op[1] ? a : 32'hFFFF_FFFF;
        end else begin
            fast_res = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // Single shift-add / restoring shift-subtract step on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_nxt   = {mul_sum, acc_q[31:1]};
        div_shift = acc_q[63:31];
        div_ge    = (div_shift >= {1'b0, opb_q});
        // When div_ge holds the true difference is below the divisor, so 32 bits suffice
        div_diff  = div_shift[31:0] - opb_q;
        div_nxt   = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
        acc_nxt   = op_q[2] ? div_nxt : mul_nxt;
    end

    // Sign correction and field selection for the completing iteration
    always_comb begin
        prod_fin = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
        quo_fin  = neg_q ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
        rem_fin  = neg_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
        if (op_q[2]) begin
            fin_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            fin_res = (op_q == OP_MUL) ? prod_fin[31:0] : prod_fin[63:32];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything including completion
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = fast ? S_DONE : S_CALC;
                S_CALC:  if (last_iter) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 5'd0;
            op_q   <= 3'd0;
            opb_q  <= 32'd0;
            acc_q  <= 64'd0;
            neg_q  <= 1'b0;
            result <= 32'd0;
        end else if (flush) begin
            cnt <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= 5'd0;
                        op_q  <= op;
                        opb_q <= b_mag;
                        acc_q <= {32'd0, a_mag};
                        neg_q <= neg_start;
                        if (fast) begin
                            result <= fast_res;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_nxt;
                    if (last_iter) begin
                        cnt    <= 5'd0;
                        result <= fin_res;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [2:0]  op = 3'd0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;
    logic chk_on = 1'b0;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .start(start), .flush(flush),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of an RV32M operation
    function automatic logic [31:0] fmodel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic [63:0] u;
        int sx;
        int sy;
        int q;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin p = longint'($signed(x)) * longint'($signed(y)); u = p; return u[31:0]; end
            3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); u = p; return u[63:32]; end
            3'd2: begin p = longint'($signed(x)) * longint'({32'd0, y}); u = p; return u[63:32]; end
            3'd3: begin u = {32'd0, x} * {32'd0, y}; return u[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                q = sx / sy; return q;
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                q = sx % sy; return q;
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    // Cycles from the accepting edge to done being visible
    function automatic int flat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1;
        if ((o == 3'b100 || o == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Timeline model: an accepted request finishes a fixed number of edges later
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic [31:0] m_pend = 32'd0;
    int          m_cyc  = 0;
    int          m_ef   = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = 32'd0;
        end else begin
            m_cyc++;
            if (flush) begin
                m_busy = 1'b0; m_done = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_pend = fmodel(op, a, b);
                    m_ef   = m_cyc + flat(op, a, b) - 1;
                    m_busy = 1'b1;
                    if (m_ef == m_cyc) begin m_res = m_pend; m_done = 1'b1; end
                end
            end else if (m_done) begin
                m_busy = 1'b0; m_done = 1'b0;
            end else if (m_cyc == m_ef) begin
                m_res = m_pend; m_done = 1'b1;
            end
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_busy",   {31'd0, busy}, {31'd0, m_busy});
            chk("cyc_done",   {31'd0, done}, {31'd0, m_done});
            chk("cyc_result", result, m_res);
        end
    end

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat, output int t_done);
        int k;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = y + 32'd1;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        t_done = tcyc;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected %0d", nm, k, exp_lat);
        end else begin
            chk({nm, "_res"}, result, exp);
            chk({nm, "_lat"}, 32'(k), 32'(exp_lat));
        end
    endtask

    initial begin
        int  t1;
        int  t2;
        bit  seen;
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        #1 chk_on = 1'b1;

        // Hand-computed pins of the model itself
        chk("pin_mul",    fmodel(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_mulhu",  fmodel(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("pin_mulhsu", fmodel(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_div",    fmodel(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem",    fmodel(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_lat",    32'(flat(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd1);

        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        rst = 1'b0;

        run("mul",      3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, t1);
        run("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, t1);
        run("mulh",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, t1);
        run("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, t1);
        run("mul_zero", 3'd0, 32'h0000_1234, 32'd0, 32'd0, 33, t1);
        run("div",      3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, t1);
        run("rem",      3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, t1);
        run("div_nb",   3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, t1);
        run("rem_nb",   3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, t1);
        run("div_z",    3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, t1);
        run("remu_z",   3'd7, 32'd5, 32'd0, 32'd5, 1, t1);
        run("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, t1);
        run("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, t1);
        run("divu",     3'd5, 32'd100, 32'd7, 32'd14, 33, t1);
        run("remu",     3'd7, 32'd100, 32'd7, 32'd2, 33, t1);

        // Flush mid-operation: result stays at 2 from REMU above
        seen = 1'b0;
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            start = (i == 10);
            flush = (i == 20);
            if (i == 10) begin a = 32'd77; b = 32'd5; op = 3'd4; end
        end
        chk("flush_busy",    {31'd0, busy}, 32'd0);
        chk("flush_result",  result, 32'd2);
        repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("flush_no_done", {31'd0, seen}, 32'd0);
        run("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 33, t1);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 32'd0);
        chk("arst_busy",   {31'd0, busy}, 32'd0);
        chk("arst_done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("arst_no_done", {31'd0, seen}, 32'd0);

        // Back-to-back: second start lands on the first IDLE edge after DONE
        run("b2b_mul",  3'd0, 32'd12, 32'd11, 32'd132, 33, t1);
        run("b2b_divu", 3'd5, 32'd50, 32'd6, 32'd8, 33, t2);
        chk("b2b_gap", 32'(t2 - t1), 32'd34);

        // A few further operands checked against the model's arithmetic
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) begin ro = 3'd4; rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            run("rand", ro, rx, ry, fmodel(ro, rx, ry), flat(ro, rx, ry), t1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
